// File: rtl/stream_scaler_pipe_if.sv
// stream_scaler_pipe_if: CSR slave plus Avalon-ST sink and source signals of stream_scaler_pipe
interface stream_scaler_pipe_if #(parameter int DATA_W = 32);
  logic [1:0] avs_address;
  logic avs_write;
  logic [31:0] avs_writedata;
  logic avs_read;
  logic [31:0] avs_readdata;
  logic asi_valid;
  logic [DATA_W-1:0] asi_data;
  logic asi_startofpacket;
  logic asi_endofpacket;
  logic asi_ready;
  logic aso_valid;
  logic [DATA_W-1:0] aso_data;
  logic aso_startofpacket;
  logic aso_endofpacket;
  logic aso_ready;
  modport slave (
    input avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata,
    input asi_valid, asi_data, asi_startofpacket, asi_endofpacket,
    output asi_ready,
    output aso_valid, aso_data, aso_startofpacket, aso_endofpacket,
    input aso_ready
  );
  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input avs_readdata,
    output asi_valid, asi_data, asi_startofpacket, asi_endofpacket,
    input asi_ready,
    input aso_valid, aso_data, aso_startofpacket, aso_endofpacket,
    output aso_ready
  );
endinterface

// File: rtl/stream_scaler_pipe.sv
// stream_scaler_pipe: 3-stage (in*A*B)>>SHIFT stream scaler with saturation, bypass and CSRs
module stream_scaler_pipe #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int SHIFT = 19,
  parameter int unsigned B_RESET = 1311
) (
  input logic clk,
  input logic reset,
  stream_scaler_pipe_if.slave bus
);
  localparam int PW = DATA_W + COEF_W;
  localparam int QW = DATA_W + 2 * COEF_W;
  logic [COEF_W-1:0] coef_a_q, coef_b_q, b1_q;
  logic [1:0] ctrl_q;
  logic [30:0] cnt_q;
  logic sticky_q;
  logic [31:0] rdata_q, rdata_d;
  logic v1_q, v2_q, v3_q;
  logic byp1_q, byp2_q, sat1_q, sat2_q;
  logic sop1_q, sop2_q, sop3_q, eop1_q, eop2_q, eop3_q;
  logic [PW-1:0] p_q;
  logic [QW-1:0] q_q, r;
  logic [DATA_W-1:0] o_q;
  logic en1, en2, en3, ovf, clr, xfer, sat_set;
  assign en3 = !v3_q || bus.aso_ready;
  assign en2 = !v2_q || en3;
  assign en1 = !v1_q || en2;
  assign r = q_q >> SHIFT;
  assign ovf = |(r >> DATA_W);
  assign clr = bus.avs_write && bus.avs_address == 2'd3;
  assign xfer = v3_q && bus.aso_ready;
  assign sat_set = en3 && v2_q && !byp2_q && sat2_q && ovf;
  assign bus.asi_ready = en1;
  assign bus.aso_valid = v3_q;
  assign bus.aso_data = o_q;
  assign bus.aso_startofpacket = sop3_q;
  assign bus.aso_endofpacket = eop3_q;
  assign bus.avs_readdata = rdata_q;
  always_comb
    rdata_d = bus.avs_address == 2'd0 ? 32'(coef_a_q) :
              bus.avs_address == 2'd1 ? 32'(coef_b_q) :
              bus.avs_address == 2'd2 ? {30'd0, ctrl_q} : {sticky_q, cnt_q};
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_a_q <= COEF_W'(1);
      coef_b_q <= COEF_W'(B_RESET);
      ctrl_q <= 2'b10;
      cnt_q <= '0;
      sticky_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (bus.avs_read) rdata_q <= rdata_d;
      if (bus.avs_write && bus.avs_address == 2'd0) coef_a_q <= bus.avs_writedata[COEF_W-1:0];
      if (bus.avs_write && bus.avs_address == 2'd1) coef_b_q <= bus.avs_writedata[COEF_W-1:0];
      if (bus.avs_write && bus.avs_address == 2'd2) ctrl_q <= bus.avs_writedata[1:0];
      // a STATUS write takes priority over a coincident output transfer or saturation
      cnt_q <= clr ? '0 : cnt_q + 31'(xfer);
      sticky_q <= clr ? 1'b0 : sticky_q | sat_set;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      o_q <= '0;
      sop3_q <= 1'b0;
      eop3_q <= 1'b0;
    end else begin
      if (en1) begin
        v1_q <= bus.asi_valid;
        p_q <= ctrl_q[0] ? PW'(bus.asi_data) : PW'(bus.asi_data) * PW'(coef_a_q);
        b1_q <= coef_b_q;
        byp1_q <= ctrl_q[0];
        sat1_q <= ctrl_q[1];
        sop1_q <= bus.asi_startofpacket;
        eop1_q <= bus.asi_endofpacket;
      end
      if (en2) begin
        v2_q <= v1_q;
        q_q <= byp1_q ? QW'(p_q) : QW'(p_q) * QW'(b1_q);
        byp2_q <= byp1_q;
        sat2_q <= sat1_q;
        sop2_q <= sop1_q;
        eop2_q <= eop1_q;
      end
      if (en3) begin
        v3_q <= v2_q;
        o_q <= byp2_q ? q_q[DATA_W-1:0] : (sat2_q && ovf) ? '1 : r[DATA_W-1:0];
        sop3_q <= sop2_q;
        eop3_q <= eop2_q;
      end
    end
  end
endmodule

// File: tb/tb_stream_scaler_pipe.sv
// tb_stream_scaler_pipe: directed stimulus checked against a spec-level scoreboard model
module tb_stream_scaler_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] d; logic s; logic e; logic st;} beat_t;
  beat_t q[$];
  logic [31:0] m_a, m_b;
  logic [1:0] m_ctrl;
  logic [30:0] m_cnt;
  logic m_sticky;
  int n_out = 0;
  logic [31:0] last_out;
  logic [1:0] last_flags;
  logic rnd_en = 1'b0;
  stream_scaler_pipe_if #(.DATA_W(32)) bus();
  stream_scaler_pipe dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic beat_t model(input logic [31:0] d, input logic s, input logic e);
    beat_t b;
    logic [127:0] r;
    r = (128'(d) * 128'(m_a) * 128'(m_b)) >> 19;
    b.s = s;
    b.e = e;
    b.st = 1'b0;
    if (m_ctrl[0]) b.d = d;
    else if (m_ctrl[1] && r > 128'hFFFF_FFFF) begin
      b.d = '1;
      b.st = 1'b1;
    end else b.d = r[31:0];
    return b;
  endfunction
  // scoreboard: handshakes observed at the negedge take effect at the following posedge
  initial begin
    logic stall_prev;
    logic [31:0] prev_d;
    beat_t b;
    stall_prev = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        m_a = 1; m_b = 1311; m_ctrl = 2'b10; m_cnt = '0; m_sticky = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (bus.aso_valid && stall_prev) chk("hold_data", bus.aso_data, prev_d);
        if (bus.asi_valid && bus.asi_ready)
          q.push_back(model(bus.asi_data, bus.asi_startofpacket, bus.asi_endofpacket));
        if (bus.aso_valid && bus.aso_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out got %h expected no beat", bus.aso_data);
          end else begin
            b = q.pop_front();
            chk("out_data", bus.aso_data, b.d);
            chk("out_flags", 32'({bus.aso_startofpacket, bus.aso_endofpacket}), 32'({b.s, b.e}));
            m_sticky = m_sticky | b.st;
          end
          m_cnt = m_cnt + 31'd1;
          n_out++;
          last_out = bus.aso_data;
          last_flags = {bus.aso_startofpacket, bus.aso_endofpacket};
        end
        if (bus.avs_write)
          case (bus.avs_address)
            2'd0: m_a = bus.avs_writedata;
            2'd1: m_b = bus.avs_writedata;
            2'd2: m_ctrl = bus.avs_writedata[1:0];
            default: begin m_cnt = '0; m_sticky = 1'b0; end
          endcase
        stall_prev = bus.aso_valid && !bus.aso_ready;
        prev_d = bus.aso_data;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rnd_en) bus.aso_ready = 1'($urandom_range(0, 1));
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
    tick();
    bus.avs_write = 1'b0;
  endtask
  task automatic csr_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus.avs_read = 1'b1; bus.avs_address = a;
    tick();
    bus.avs_read = 1'b0;
    chk(nm, bus.avs_readdata, exp);
  endtask
  task automatic send(input logic [31:0] d, input logic s, input logic e);
    logic r;
    int n;
    n = 0;
    bus.asi_valid = 1'b1; bus.asi_data = d; bus.asi_startofpacket = s; bus.asi_endofpacket = e;
    do begin
      @(negedge clk);
      r = bus.asi_ready;
      tick();
      n++;
    end while (!r && n < 200);
    if (!r) chk("send_timeout", 32'(r), 32'd1);
    bus.asi_valid = 1'b0; bus.asi_startofpacket = 1'b0; bus.asi_endofpacket = 1'b0;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while ((q.size() != 0 || bus.aso_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask
  task automatic latency(input string nm);
    int n;
    n = 1;
    while (!bus.aso_valid && n < 10) begin
      tick();
      n++;
    end
    chk(nm, 32'(n), 32'd3);
  endtask
  initial begin
    int acc, n0;
    logic r;
    bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
    bus.asi_valid = 1'b0; bus.asi_data = '0; bus.asi_startofpacket = 1'b0; bus.asi_endofpacket = 1'b0;
    bus.aso_ready = 1'b1;
    repeat (3) tick();
    chk("rst_aso_valid", 32'(bus.aso_valid), 32'd0);
    chk("rst_aso_data", bus.aso_data, 32'd0);
    chk("rst_readdata", bus.avs_readdata, 32'd0);
    chk("rst_asi_ready", 32'(bus.asi_ready), 32'd1);
    reset = 1'b0;
    csr_read(2'd0, 32'd1, "rd_coef_a");
    csr_read(2'd1, 32'd1311, "rd_coef_b");
    csr_read(2'd2, 32'h2, "rd_ctrl");
    csr_read(2'd3, 32'h0, "rd_status");
    chk("rd_hold", bus.avs_readdata, 32'h0);
    send(32'd400, 1'b0, 1'b0);
    latency("lat_400");
    drain();
    chk("out_400", last_out, 32'd1);
    send(32'd800000, 1'b0, 1'b0);
    latency("lat_800000");
    drain();
    chk("out_800000", last_out, 32'd2000);
    csr_read(2'd3, 32'd2, "status_2");
    csr_write(2'd0, 32'd3);
    send(32'd400000, 1'b0, 1'b0);
    tick();
    csr_write(2'd0, 32'd5);
    drain();
    chk("out_a3", last_out, 32'd3000);
    send(32'd400000, 1'b0, 1'b0);
    drain();
    chk("out_a5", last_out, 32'd5001);
    csr_write(2'd0, 32'h0010_0000);
    csr_write(2'd1, 32'h0008_0000);
    send(32'h0001_0000, 1'b0, 1'b0);
    drain();
    chk("out_sat", last_out, 32'hFFFF_FFFF);
    csr_read(2'd3, 32'h8000_0005, "status_sticky");
    csr_write(2'd2, 32'h0);
    send(32'h0001_0000, 1'b0, 1'b0);
    drain();
    chk("out_trunc", last_out, 32'h0);
    csr_read(2'd3, 32'h8000_0006, "status_keep");
    csr_write(2'd3, 32'h0);
    csr_read(2'd3, 32'h0, "status_clr");
    csr_write(2'd2, 32'h3);
    csr_read(2'd2, 32'h3, "rd_ctrl_byp");
    send(32'hDEAD_BEEF, 1'b1, 1'b1);
    latency("lat_bypass");
    drain();
    chk("out_bypass", last_out, 32'hDEAD_BEEF);
    chk("flags_bypass", 32'(last_flags), 32'h3);
    csr_read(2'd3, 32'h1, "status_byp");
    csr_write(2'd2, 32'h2);
    csr_write(2'd0, 32'd1);
    csr_write(2'd1, 32'd1311);
    n0 = n_out;
    rnd_en = 1'b1;
    for (int i = 0; i < 20; i++) send(32'(i), i == 0, i == 19);
    csr_write(2'd2, 32'h3);
    for (int i = 0; i < 20; i++) send(32'(100 + i * 7), i == 0, i == 19);
    rnd_en = 1'b0;
    bus.aso_ready = 1'b1;
    drain();
    chk("rand_count", 32'(n_out - n0), 32'd40);
    chk("rand_last", last_out, 32'd233);
    csr_read(2'd3, {m_sticky, m_cnt}, "status_rand");
    bus.aso_ready = 1'b0;
    bus.asi_valid = 1'b1;
    bus.asi_data = 32'd200;
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      r = bus.asi_ready;
      tick();
      if (r) begin
        acc++;
        bus.asi_data = bus.asi_data + 32'd1;
      end
    end
    bus.asi_valid = 1'b0;
    chk("stall_accept", 32'(acc), 32'd3);
    chk("stall_ready", 32'(bus.asi_ready), 32'd0);
    chk("stall_head", bus.aso_data, 32'd200);
    bus.aso_ready = 1'b1;
    drain();
    chk("stall_last", last_out, 32'd202);
    csr_write(2'd0, 32'd7);
    csr_write(2'd1, 32'd9);
    csr_write(2'd2, 32'h1);
    bus.aso_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'(500 + i), 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk("flush_valid", 32'(bus.aso_valid), 32'd0);
    chk("flush_readdata", bus.avs_readdata, 32'd0);
    reset = 1'b0;
    csr_read(2'd0, 32'd1, "flush_coef_a");
    csr_read(2'd1, 32'd1311, "flush_coef_b");
    csr_read(2'd2, 32'h2, "flush_ctrl");
    csr_read(2'd3, 32'h0, "flush_status");
    n0 = n_out;
    bus.aso_ready = 1'b1;
    repeat (10) tick();
    chk("flush_no_out", 32'(n_out - n0), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
